// File: rtl/image_sensor_frontend.sv
// image_sensor_frontend: crops a window out of a parallel camera pixel stream and tags frame/line boundaries
// Ports: i_image_sensor_pclk clock, i_rst_n synchronous active-low reset;
//    i_image_sensor_vsync/href/data sensor bus (frame valid, line valid, 8-bit pixel);
//    o_pix_vld/o_pix_data cropped pixels, o_sof/o_eol/o_eof markers qualified by o_pix_vld;
//    o_frame_err pulse when a started frame ends without its last window line;
//    o_meas_width/o_meas_height/o_line_err line/frame statistics, only built with
//    IMAGE_SENSOR_FRONTEND_STATS_EN defined (tied to 0 otherwise).
module image_sensor_frontend #(
   parameter int P_H_START  = 56,
   parameter int P_H_WIDTH  = 640,
   parameter int P_V_START  = 0,
   parameter int P_V_HEIGHT = 480
) (
   input  logic        i_image_sensor_pclk,
   input  logic        i_rst_n,
   input  logic        i_image_sensor_vsync,
   input  logic        i_image_sensor_href,
   input  logic [7:0]  i_image_sensor_data,
   output logic        o_pix_vld,
   output logic [7:0]  o_pix_data,
   output logic        o_sof,
   output logic        o_eol,
   output logic        o_eof,
   output logic        o_frame_err,
   output logic [10:0] o_meas_width,
   output logic [9:0]  o_meas_height,
   output logic        o_line_err
);
   localparam logic [10:0] H_FIRST = 11'(P_H_START);
   localparam logic [10:0] H_LAST  = 11'(P_H_START + P_H_WIDTH - 1);
   localparam logic [10:0] H_W     = 11'(P_H_WIDTH);
   localparam logic [9:0]  V_FIRST = 10'(P_V_START);
   localparam logic [9:0]  V_LAST  = 10'(P_V_START + P_V_HEIGHT - 1);
   localparam logic [9:0]  V_H     = 10'(P_V_HEIGHT);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FRAME} state_t;
   state_t      state, state_nxt;
   logic        live, vsync_r, vsync_d, href_r;
   logic [7:0]  data_r;
   logic [10:0] hcnt, h_off;
   logic [9:0]  vcnt, v_off;
   logic        sof_seen, eof_seen;
   logic        v_rise, v_fall, h_fall, pix, sof, eol, eof;
   // live holds the FSM in S_IDLE until vsync_r carries a real sample, so a
   // frame already running at reset release is never mistaken for a fresh one.
   always_comb begin
      v_rise = vsync_r & ~vsync_d;
      v_fall = ~vsync_r & vsync_d;
      h_fall = ~href_r & (hcnt != '0);
      h_off = hcnt - H_FIRST;
      v_off = vcnt - V_FIRST;
      pix = state == S_FRAME && vsync_r && href_r && h_off < H_W && v_off < V_H;
      sof = pix && hcnt == H_FIRST && vcnt == V_FIRST;
      eol = pix && hcnt == H_LAST;
      eof = eol && vcnt == V_LAST;
      state_nxt = state == S_IDLE ? ((live && !vsync_r) ? S_WAIT : S_IDLE) :
                  state == S_WAIT ? (v_rise ? S_FRAME : S_WAIT) :
                  (v_fall ? S_WAIT : S_FRAME);
   end
   always_ff @(posedge i_image_sensor_pclk) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         live        <= 1'b0;
         vsync_r     <= 1'b0;
         vsync_d     <= 1'b0;
         href_r      <= 1'b0;
         data_r      <= '0;
         hcnt        <= '0;
         vcnt        <= '0;
         sof_seen    <= 1'b0;
         eof_seen    <= 1'b0;
         o_pix_vld   <= 1'b0;
         o_pix_data  <= '0;
         o_sof       <= 1'b0;
         o_eol       <= 1'b0;
         o_eof       <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         live        <= 1'b1;
         vsync_r     <= i_image_sensor_vsync;
         vsync_d     <= vsync_r;
         href_r      <= i_image_sensor_href;
         data_r      <= i_image_sensor_data;
         hcnt        <= !href_r ? '0 : (&hcnt ? hcnt : hcnt + 11'd1);
         vcnt        <= v_rise ? '0 : (vsync_r && h_fall && !(&vcnt)) ? vcnt + 10'd1 : vcnt;
         sof_seen    <= v_rise ? 1'b0 : sof_seen | sof;
         eof_seen    <= v_rise ? 1'b0 : eof_seen | eof;
         o_pix_vld   <= pix;
         o_pix_data  <= pix ? data_r : '0;
         o_sof       <= sof;
         o_eol       <= eol;
         o_eof       <= eof;
         o_frame_err <= state == S_FRAME && v_fall && sof_seen && !eof_seen;
      end
   end
`ifdef IMAGE_SENSOR_FRONTEND_STATS_EN
   logic have_prev;
   // o_meas_width doubles as the previous line length for the mismatch check.
   always_ff @(posedge i_image_sensor_pclk) begin
      if (!i_rst_n) begin
         o_meas_width  <= '0;
         o_meas_height <= '0;
         o_line_err    <= 1'b0;
         have_prev     <= 1'b0;
      end else begin
         o_meas_width  <= h_fall ? hcnt : o_meas_width;
         o_meas_height <= v_fall ? vcnt : o_meas_height;
         o_line_err    <= h_fall && have_prev && hcnt != o_meas_width;
         have_prev     <= have_prev | h_fall;
      end
   end
`else
   assign o_meas_width  = '0;
   assign o_meas_height = '0;
   assign o_line_err    = 1'b0;
`endif
endmodule

// File: tb/tb_image_sensor_frontend.sv
// tb_image_sensor_frontend: directed frames against a pixel-level model of the cropping front end
module tb_image_sensor_frontend;
   localparam int P_HS = 56, P_HW = 640, P_VS = 1, P_VH = 4;
`ifdef IMAGE_SENSOR_FRONTEND_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   typedef struct packed {
      logic        vld;
      logic [7:0]  data;
      logic        sof, eol, eof, ferr;
      logic [10:0] w;
      logic [9:0]  h;
      logic        lerr;
   } exp_t;
   logic        clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, href = 1'b0;
   logic [7:0]  data = '0;
   logic        o_pix_vld, o_sof, o_eol, o_eof, o_frame_err, o_line_err;
   logic [7:0]  o_pix_data;
   logic [10:0] o_meas_width;
   logic [9:0]  o_meas_height;
   exp_t        exp_in = '0, p1 = '0, p2 = '0;
   int          n_checks = 0, n_fail = 0, cyc = 0;
   int          cnt_vld, cnt_sof, cnt_eol, cnt_eof, cnt_ferr, cnt_lerr;
   int          sof_drv = -1, sof_obs = -1;
   logic [7:0]  sof_dat = '0;
   bit          m_vs, m_href, m_cap, m_armed, m_sof, m_eof, m_have;
   int          m_pix, m_lines, m_w, m_h;

   image_sensor_frontend #(.P_H_START(P_HS), .P_H_WIDTH(P_HW), .P_V_START(P_VS), .P_V_HEIGHT(P_VH)) dut (
      .i_image_sensor_pclk(clk), .i_rst_n(rst_n), .i_image_sensor_vsync(vsync),
      .i_image_sensor_href(href), .i_image_sensor_data(data), .o_pix_vld(o_pix_vld),
      .o_pix_data(o_pix_data), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
      .o_frame_err(o_frame_err), .o_meas_width(o_meas_width), .o_meas_height(o_meas_height),
      .o_line_err(o_line_err));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
      end
   endtask

   // Model: a pixel is in the window if its index in the line and the number of
   // lines already completed in the frame fall inside the crop rectangle.
   task automatic step(input logic vs, input logic hr, input logic [7:0] d);
      exp_t e;
      int p;
      e = '0;
      if (vs && !m_vs) begin m_cap = m_armed; m_lines = 0; m_sof = 0; m_eof = 0; end
      if (!vs && m_vs) begin e.ferr = m_cap && m_sof && !m_eof; m_h = m_lines; m_cap = 0; end
      if (!vs) m_armed = 1;
      if (hr) begin
         p = m_pix;
         m_pix++;
         e.vld = m_cap && vs && p >= P_HS && p < P_HS + P_HW && m_lines >= P_VS && m_lines < P_VS + P_VH;
         e.data = e.vld ? d : 8'h00;
         e.sof = e.vld && p == P_HS && m_lines == P_VS;
         e.eol = e.vld && p == P_HS + P_HW - 1;
         e.eof = e.eol && m_lines == P_VS + P_VH - 1;
         m_sof |= e.sof;
         m_eof |= e.eof;
      end else if (m_href) begin
         e.lerr = STATS && m_have && m_pix != m_w;
         m_w = m_pix;
         m_have = 1;
         m_pix = 0;
         if (vs) m_lines++;
      end
      m_href = hr;
      m_vs = vs;
      e.w = STATS ? 11'(m_w) : '0;
      e.h = STATS ? 10'(m_h) : '0;
      if (e.sof && sof_drv < 0) sof_drv = cyc;
      exp_in = e;
      vsync = vs;
      href = hr;
      data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic line(input int len, input logic vs, input int seed, input int gap);
      for (int i = 0; i < len; i++) step(vs, 1'b1, (i == 56 && seed == 1) ? 8'hA5 : 8'(i * 7 + seed * 13));
      for (int i = 0; i < gap; i++) step(vs, 1'b0, 8'h00);
   endtask

   task automatic frame(input int nlines, input int len);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
      for (int l = 0; l < nlines; l++) line(len, 1'b1, l, 8);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      exp_in = '0;
      repeat (n) begin @(posedge clk); #1; end
      m_vs = 0; m_href = 0; m_cap = 0; m_armed = 0; m_sof = 0; m_eof = 0; m_have = 0;
      m_pix = 0; m_lines = 0; m_w = 0; m_h = 0;
      rst_n = 1'b1;
   endtask

   task automatic clr();
      cnt_vld = 0; cnt_sof = 0; cnt_eol = 0; cnt_eof = 0; cnt_ferr = 0; cnt_lerr = 0;
   endtask

   task automatic counts(input string tag, input int v, input int s, input int el, input int ef, input int fe);
      check({tag, "_vld_count"}, cnt_vld, v);
      check({tag, "_sof_count"}, cnt_sof, s);
      check({tag, "_eol_count"}, cnt_eol, el);
      check({tag, "_eof_count"}, cnt_eof, ef);
      check({tag, "_frame_err_count"}, cnt_ferr, fe);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin p1 = '0; p2 = '0; end
         else begin p2 = p1; p1 = exp_in; end
         @(negedge clk);
         check("pix_vld", o_pix_vld, p2.vld);
         check("pix_data", o_pix_data, p2.data);
         check("markers", {o_sof, o_eol, o_eof}, {p2.sof, p2.eol, p2.eof});
         check("frame_err", o_frame_err, p2.ferr);
         check("stats", {o_meas_width, o_meas_height, o_line_err}, {p2.w, p2.h, p2.lerr});
         if (o_pix_vld) cnt_vld++;
         if (o_pix_vld && o_sof) cnt_sof++;
         if (o_pix_vld && o_eol) cnt_eol++;
         if (o_pix_vld && o_eof) cnt_eof++;
         if (o_frame_err) cnt_ferr++;
         if (o_line_err) cnt_lerr++;
         if (o_pix_vld && o_sof && sof_obs < 0) begin sof_obs = cyc; sof_dat = o_pix_data; end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      clr();
      @(posedge clk);
      #1;
      do_reset(4);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("reset_outputs", {o_pix_vld, o_pix_data, o_sof, o_eol, o_eof, o_frame_err,
                              o_meas_width, o_meas_height, o_line_err}, 0);
      do_reset(1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
      // full frame: 6 lines of 752, window lines 1..4
      clr();
      frame(6, 752);
      counts("full", 2560, 1, 4, 1, 0);
      check("first_pixel_latency", sof_obs - sof_drv, 2);
      check("first_pixel_data", sof_dat, 8'hA5);
      check("full_meas_width", o_meas_width, STATS ? 752 : 0);
      check("full_meas_height", o_meas_height, STATS ? 6 : 0);
      check("full_line_err_count", cnt_lerr, 0);
      // vsync drops before the last window line
      clr();
      frame(3, 752);
      counts("short_frame", 1280, 1, 2, 0, 1);
      check("short_meas_height", o_meas_height, STATS ? 3 : 0);
      // stray line with vsync low, then uneven line lengths
      clr();
      line(100, 1'b0, 0, 8);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
      line(752, 1'b1, 0, 8);
      line(700, 1'b1, 1, 8);
      line(600, 1'b1, 2, 8);
      line(752, 1'b1, 3, 8);
      line(752, 1'b1, 4, 8);
      line(752, 1'b1, 5, 8);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
      counts("uneven", 2464, 1, 3, 1, 0);
      check("uneven_line_err_count", cnt_lerr, STATS ? 5 : 0);
      check("uneven_meas_height", o_meas_height, STATS ? 6 : 0);
      // reset in the middle of a frame, then a clean frame
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
      line(752, 1'b1, 0, 8);
      line(752, 1'b1, 1, 8);
      do_reset(3);
      clr();
      for (int l = 2; l < 6; l++) line(752, 1'b1, l, 8);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
      counts("after_reset", 0, 0, 0, 0, 0);
      check("after_reset_meas_height", o_meas_height, STATS ? 4 : 0);
      clr();
      frame(6, 752);
      counts("recovered", 2560, 1, 4, 1, 0);
      check("recovered_meas_width", o_meas_width, STATS ? 752 : 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/image_sensor_frontend.md
IMAGE_SENSOR_FRONTEND -- requirements
Module: image_sensor_frontend

Interface
REQ-001 SHALL have parameter P_H_START, default 56, first captured pixel index within a line.
REQ-002 SHALL have parameter P_H_WIDTH, default 640, captured pixels per line.
REQ-003 SHALL have parameter P_V_START, default 0, first captured line index within a frame.
REQ-004 SHALL have parameter P_V_HEIGHT, default 480, captured lines per frame.
REQ-005 SHALL have port i_image_sensor_pclk, input, 1, sensor pixel clock; all logic on rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, reset: synchronous, active-low, sampled on i_image_sensor_pclk.
REQ-007 SHALL have port i_image_sensor_vsync, input, 1, frame valid, high for the whole frame.
REQ-008 SHALL have port i_image_sensor_href, input, 1, line valid, high while a line's pixels are present.
REQ-009 SHALL have port i_image_sensor_data, input, 8, pixel data.
REQ-010 SHALL have port o_pix_vld, output, 1, cropped pixel valid.
REQ-011 SHALL have port o_pix_data, output, 8, cropped pixel data.
REQ-012 SHALL have ports o_sof, o_eol, o_eof, output, 1 each, start-of-frame, end-of-line and end-of-frame markers, qualified by o_pix_vld.
REQ-013 SHALL have port o_frame_err, output, 1, one-cycle pulse: frame ended incomplete.
REQ-014 SHALL have ports o_meas_width (11), o_meas_height (10), o_line_err (1), outputs, stats (see Configuration).

Function
REQ-015 SHALL register vsync, href and data once; registered data drives o_pix_data after a second register; input-to-output latency exactly 2 pclk edges.
REQ-016 SHALL keep an 11-bit pixel counter hcnt: 0 while href low, +1 per href-high cycle, saturating at 2047.
REQ-017 SHALL keep a 10-bit line counter vcnt: cleared at vsync rising edge, +1 at each href falling edge, saturating at 1023.
REQ-018 SHALL implement FSM S_IDLE -> S_WAIT (vsync seen low) -> S_FRAME (vsync rising edge) -> S_WAIT (vsync falling edge).
REQ-019 SHALL assert o_pix_vld only in S_FRAME with href high, P_H_START <= hcnt <= P_H_START+P_H_WIDTH-1 and P_V_START <= vcnt <= P_V_START+P_V_HEIGHT-1.
REQ-020 SHALL assert o_sof with the pixel at hcnt==P_H_START, vcnt==P_V_START; o_eol with hcnt==P_H_START+P_H_WIDTH-1; o_eof coincident with o_eol on vcnt==P_V_START+P_V_HEIGHT-1.
REQ-021 SHALL pulse o_frame_err one cycle after a vsync falling edge in S_FRAME when o_sof was emitted but o_eof was not.
REQ-022 SHALL emit no pixels or markers for a line shorter than the window beyond the pixels actually present; o_eol is then absent.
REQ-023 SHALL treat href high while vsync low as ignored (no o_pix_vld, vcnt unchanged).
REQ-024 SHALL drive o_pix_data to 0 when o_pix_vld is low.

Reset
REQ-025 SHALL, while i_rst_n low, force FSM to S_IDLE, counters, pipeline registers and all outputs to 0.
REQ-026 SHALL discard any frame in progress at reset release: capture starts only at a vsync rising edge after vsync was seen low.

Configuration
REQ-027 SHALL compile frame statistics only when macro IMAGE_SENSOR_FRONTEND_STATS_EN is defined.
REQ-028 SHALL, with the macro, load o_meas_width with hcnt at each href falling edge, o_meas_height with vcnt at each vsync falling edge, and pulse o_line_err one cycle when a completed line length differs from the previous line's.
REQ-029 SHALL, without the macro, tie o_meas_width, o_meas_height, o_line_err to 0 and instantiate no stats registers.

Verification
REQ-030 SHALL cover: defaults, 752x480 frame -> 640 o_pix_vld per line, 480 lines, hcnt 56..695 passed, one o_sof, 480 o_eol, one o_eof.
REQ-031 SHALL cover: first data byte 0xA5 on input at edge k -> o_pix_data 0xA5 with o_pix_vld after edge k+2.
REQ-032 SHALL cover: reset released mid-frame (vsync high) -> zero o_pix_vld until the next full frame, which is captured completely.
REQ-033 SHALL cover: vsync falls after 200 lines -> o_frame_err single pulse, no o_eof.
REQ-034 SHALL cover: stats enabled, 752x480 frame -> o_meas_width 752, o_meas_height 480; one 700-pixel line -> o_line_err pulses; stats disabled -> all three stay 0.
